slice_coeff_seq: RTL and testbench
==================================

# slice_coeff_seq

Pixel-side sequencer for a slice accumulator. It stores the coefficient table for one window row, loaded serially during download. For every valid pixel it emits the matching signed coefficient together with the registered pixel, its valid strobe and an end-of-block pulse. All outputs are aligned on the same cycle so the slice accumulator directly downstream can sample them without extra delay.

## Interface
- DWIDTH, 8, pixel width
- CWIDTH, 9, signed coefficient width
- BLOCKSIZE, 32, pixels per block (power of 2)
- WINCOLS, 8, blocks per window (power of 2)
- IMWIDTH, 320, pixels per line (multiple of BLOCKSIZE)
- Table depth: DEPTH = WINCOLS*BLOCKSIZE

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- data_i  in  DWIDTH  pixel
- dvi_i  in  1  pixel valid
- fv_i  in  1  frame valid; counters held at 0 while low
- download  in  1  table load mode
- coeff_i  in  CWIDTH  coefficient to write (signed)
- coeff_we  in  1  write strobe, honoured only while download=1
- data_o  out  DWIDTH  registered pixel
- dvi_o  out  1  registered valid
- svcoeff_o  out  CWIDTH  signed coefficient for data_o
- newblock_o  out  1  high with last pixel of each block
- loaded_o  out  1  table fully written
- ovf_o  out  1  sticky: write attempted past DEPTH

## Operation
- Counters:
  - pix: 0..BLOCKSIZE-1
  - blk: 0..WINCOLS-1, modulo WINCOLS
  - col: 0..IMWIDTH-1
- Counters advance only on accepted pixels: dvi_i=1, fv_i=1, download=0.
- Counter update on an accepted pixel:
  - pix increments; at BLOCKSIZE-1 it wraps to 0 and blk increments.
  - At col=IMWIDTH-1, pix, blk and col all clear to 0, regardless of blk value.
- Read index for an accepted pixel = blk*BLOCKSIZE + pix, taken from the counter values before the increment.
- Table: DEPTH x CWIDTH, synchronous read, single write port.
- Write pointer wptr:
  - Cleared on the rising edge of download.
  - On each coeff_we while download=1: if wptr<DEPTH, write mem[wptr] and increment wptr; else drop the write and set ovf_o.
- loaded_o: set when wptr reaches DEPTH. loaded_o and ovf_o clear on the next rising edge of download.
- While download=1:
  - dvi_o=0, newblock_o=0, svcoeff_o=0.
  - pix, blk and col clear to 0.
  - Pixels on data_i are ignored.
- fv_i=0 clears pix, blk and col. dvi_o follows accepted pixels only.
- The table is not cleared by reset. Contents are undefined until loaded; the block still streams.
- Reset values: data_o=0, dvi_o=0, svcoeff_o=0, newblock_o=0, loaded_o=0, ovf_o=0, all counters and wptr=0.

## Timing
- Latency is 1 cycle. An accepted pixel in cycle N gives, in cycle N+1:
  - dvi_o=1
  - data_o = that pixel
  - svcoeff_o = mem[index]
  - newblock_o=1 if pix was BLOCKSIZE-1 (also at line end)
- Cycles without an accepted pixel produce dvi_o=0 and newblock_o=0. svcoeff_o and data_o hold their last values.
- Back-to-back pixels are supported at full rate, with no bubbles.
- A write at cycle N is readable from cycle N+1. Read and write in the same cycle cannot occur, since streaming is blocked while download=1.
- Download asserted in the middle of a line: the following cycle's dvi_o=0. After download deasserts, counting restarts at index 0.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). The first accepted pixel after release uses index 0.
- ovf_o sets in the cycle after the offending write.

## Test plan
- Reset, download, write DEPTH=256 values mem[i]=i-128 -> loaded_o=1 the cycle after the 256th write, ovf_o=0. Then 320 pixels data=i -> svcoeff_o sequence -128..127 followed by -128..-65, each aligned with data_o=i.
- Same stream -> newblock_o high on outputs 31, 63, ..., 319 (10 pulses), coincident with dvi_o.
- Gapped dvi_i (one pixel every 3 cycles) -> identical svcoeff_o and newblock_o sequence as the full-rate run; dvi_o high only 1 cycle after each input.
- 257 writes -> loaded_o=1, ovf_o=1, and mem[0] is unchanged. Next download rise -> both flags clear.
- Download asserted after 40 pixels -> dvi_o=0 from the next cycle. After deassert, the first pixel gets mem[0] and newblock_o is first seen after 32 pixels.
- reset_n pulsed after 100 pixels -> all outputs 0 within that cycle; next pixel gets mem[0]. fv_i dropped after 50 pixels then raised -> index restarts at 0.

Source files
------------

// File: rtl/slice_coeff_seq.sv
// slice_coeff_seq: coefficient sequencer feeding a slice accumulator.
// Holds one window row of signed coefficients (loaded serially while
// download=1) and, for every accepted pixel, presents the pixel, its valid
// strobe, the matching coefficient and an end-of-block pulse one cycle later.
module slice_coeff_seq #(
    parameter int DWIDTH    = 8,
    parameter int CWIDTH    = 9,
    parameter int BLOCKSIZE = 32,
    parameter int WINCOLS   = 8,
    parameter int IMWIDTH   = 320
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              dvi_i,
    input  logic              fv_i,
    input  logic              download,
    input  logic [CWIDTH-1:0] coeff_i,
    input  logic              coeff_we,
    output logic [DWIDTH-1:0] data_o,
    output logic              dvi_o,
    output logic [CWIDTH-1:0] svcoeff_o,
    output logic              newblock_o,
    output logic              loaded_o,
    output logic              ovf_o
);

    localparam int DEPTH = WINCOLS * BLOCKSIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(BLOCKSIZE);
    localparam int BW    = $clog2(WINCOLS);
    localparam int CW    = $clog2(IMWIDTH);

    // Position counters within the current line
    logic [PW-1:0] pix_reg, pix_next;
    logic [BW-1:0] blk_reg, blk_next;
    logic [CW-1:0] col_reg, col_next;

    // Table write side
    logic [AW:0]   wptr_reg, wptr_next, wptr_base;
    logic          download_d_reg;
    logic          dl_rise, wr_ok, wr_drop;

    // Table storage and registered read data
    logic [CWIDTH-1:0] mem [DEPTH];
    logic [CWIDTH-1:0] rd_data_reg;
    logic              coeff_zero_reg;

    logic          accept;
    logic          pix_last, col_last;
    logic [AW-1:0] rd_idx;

    assign accept   = dvi_i & fv_i & ~download;
    assign pix_last = (pix_reg == PW'(BLOCKSIZE - 1));
    assign col_last = (col_reg == CW'(IMWIDTH - 1));
    // Power-of-two sizes make blk*BLOCKSIZE+pix a plain concatenation
    assign rd_idx   = {blk_reg, pix_reg};

    // A write in the same cycle as the download rise goes to entry 0
    assign dl_rise   = download & ~download_d_reg;
    assign wptr_base = dl_rise ? '0 : wptr_reg;
    assign wr_ok     = download & coeff_we & (wptr_base < (AW+1)'(DEPTH));
    assign wr_drop   = download & coeff_we & ~wr_ok;
    assign wptr_next = wr_ok ? wptr_base + (AW+1)'(1) : wptr_base;

    // Next-state logic for the pix/blk/col counters
    always_comb begin
        pix_next = pix_reg;
        blk_next = blk_reg;
        col_next = col_reg;
        if (download || !fv_i) begin
            pix_next = '0;
            blk_next = '0;
            col_next = '0;
        end else if (dvi_i) begin
            if (col_last) begin
                pix_next = '0;
                blk_next = '0;
                col_next = '0;
            end else begin
                col_next = col_reg + CW'(1);
                if (pix_last) begin
                    pix_next = '0;
                    blk_next = blk_reg + BW'(1);
                end else begin
                    pix_next = pix_reg + PW'(1);
                end
            end
        end
    end

    // Counter, write pointer and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_reg        <= '0;
            blk_reg        <= '0;
            col_reg        <= '0;
            wptr_reg       <= '0;
            download_d_reg <= 1'b0;
            loaded_o       <= 1'b0;
            ovf_o          <= 1'b0;
        end else begin
            pix_reg        <= pix_next;
            blk_reg        <= blk_next;
            col_reg        <= col_next;
            wptr_reg       <= wptr_next;
            download_d_reg <= download;
            loaded_o       <= (wptr_next == (AW+1)'(DEPTH));
            ovf_o          <= (dl_rise ? 1'b0 : ovf_o) | wr_drop;
        end
    end

    // Coefficient table write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_base[AW-1:0]] <= coeff_i;
        end
    end

    // Registered table read, updated only for accepted pixels so it holds otherwise
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    // Pixel-side output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o         <= '0;
            dvi_o          <= 1'b0;
            newblock_o     <= 1'b0;
            coeff_zero_reg <= 1'b1;
        end else begin
            dvi_o      <= accept;
            newblock_o <= accept & (pix_last | col_last);
            if (accept) begin
                data_o <= data_i;
            end
            // Coefficient output is forced to zero after reset and during download
            if (download) begin
                coeff_zero_reg <= 1'b1;
            end else if (accept) begin
                coeff_zero_reg <= 1'b0;
            end
        end
    end

    assign svcoeff_o = coeff_zero_reg ? '0 : rd_data_reg;

endmodule

// File: tb/tb_slice_coeff_seq.sv
// Testbench for slice_coeff_seq: table vectors, directed corner sequences
// and randomized traffic checked against a line-position reference model.
module tb_slice_coeff_seq;

    localparam int DEPTH = 256;
    localparam int BS    = 32;
    localparam int IMW   = 320;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_i;
    logic       dvi_i, fv_i, download, coeff_we;
    logic [8:0] coeff_i;
    logic [7:0] data_o;
    logic       dvi_o, newblock_o, loaded_o, ovf_o;
    logic [8:0] svcoeff_o;

    slice_coeff_seq dut (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .dvi_i(dvi_i),
        .fv_i(fv_i), .download(download), .coeff_i(coeff_i),
        .coeff_we(coeff_we), .data_o(data_o), .dvi_o(dvi_o),
        .svcoeff_o(svcoeff_o), .newblock_o(newblock_o),
        .loaded_o(loaded_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: line position, table image, write count, expected outputs
    int ref_mem [DEPTH];
    bit ref_valid [DEPTH];
    int m_pos, m_wptr;
    bit m_dl_prev;
    int e_data, e_coeff;
    bit e_dvi, e_nb, e_loaded, e_ovf, e_cvalid;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sc(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    // One clock: drive inputs, advance model, sample after the edge, compare
    task automatic cycle(input bit dl, input bit we, input int cf,
                         input bit dv, input bit fv, input int d);
        bit rise;
        download = dl; coeff_we = we; coeff_i = 9'(cf);
        dvi_i = dv; fv_i = fv; data_i = 8'(d);
        rise = dl && !m_dl_prev;
        m_dl_prev = dl;
        if (dl) begin
            if (rise) begin
                m_wptr = 0;
                e_ovf = 0;
            end
            if (we) begin
                if (m_wptr < DEPTH) begin
                    ref_mem[m_wptr] = cf;
                    ref_valid[m_wptr] = 1;
                    m_wptr++;
                end else begin
                    e_ovf = 1;
                end
            end
        end
        e_loaded = (m_wptr == DEPTH);
        if (dl) begin
            e_dvi = 0; e_nb = 0; e_coeff = 0; e_cvalid = 1; m_pos = 0;
        end else if (!fv) begin
            e_dvi = 0; e_nb = 0; m_pos = 0;
        end else if (dv) begin
            e_dvi = 1;
            e_data = d & 8'hff;
            e_coeff = ref_mem[m_pos % DEPTH];
            e_cvalid = ref_valid[m_pos % DEPTH];
            e_nb = ((m_pos % BS) == BS - 1);
            m_pos = (m_pos + 1) % IMW;
        end else begin
            e_dvi = 0; e_nb = 0;
        end
        @(posedge clk); #1;
        chk("dvi_o", dvi_o, e_dvi);
        chk("newblock_o", newblock_o, e_nb);
        chk("data_o", data_o, e_data);
        if (e_cvalid) chk("svcoeff_o", sc(svcoeff_o), e_coeff);
        chk("loaded_o", loaded_o, e_loaded);
        chk("ovf_o", ovf_o, e_ovf);
    endtask

    task automatic pix(input int d);
        cycle(0, 0, 0, 1, 1, d);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_o"}, data_o, 0);
        chk({tag, "_dvi_o"}, dvi_o, 0);
        chk({tag, "_svcoeff_o"}, sc(svcoeff_o), 0);
        chk({tag, "_newblock_o"}, newblock_o, 0);
        chk({tag, "_loaded_o"}, loaded_o, 0);
        chk({tag, "_ovf_o"}, ovf_o, 0);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        m_pos = 0; m_wptr = 0; m_dl_prev = 0;
        e_data = 0; e_coeff = 0; e_dvi = 0; e_nb = 0;
        e_loaded = 0; e_ovf = 0; e_cvalid = 1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Download the ramp table mem[i]=i-128 plus optional extra writes
    task automatic load_ramp(input int extra);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 1, i - 128, 0, 1, 0);
            if (i == DEPTH - 2) chk("loaded_before_last", loaded_o, 0);
        end
        chk("loaded_after_256", loaded_o, 1);
        chk("ovf_after_256", ovf_o, 0);
        for (int i = 0; i < extra; i++) cycle(1, 1, 77, 0, 1, 0);
    endtask

    typedef struct {
        bit dl; bit dv; bit fv; int d;
        bit x_dvi; bit x_nb; int x_data; int x_coeff;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int nb_cnt, dvi_cnt, r_dl;

        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 0; ref_valid[i] = 0; end
        m_pos = 0; m_wptr = 0; m_dl_prev = 0;
        e_data = 0; e_coeff = 0; e_dvi = 0; e_nb = 0;
        e_loaded = 0; e_ovf = 0; e_cvalid = 1;
        reset_n = 1'b0; download = 0; coeff_we = 0; coeff_i = 0;
        dvi_i = 0; fv_i = 0; data_i = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        reset_n = 1'b1;

        // Full table load
        load_ramp(0);
        cycle(0, 0, 0, 0, 0, 0);

        // Table-driven short sequence (table mem[i]=i-128, position 0)
        vecs[0] = '{0, 1, 1, 5,  1, 0, 5,  -128};
        vecs[1] = '{0, 0, 1, 6,  0, 0, 5,  -128};
        vecs[2] = '{0, 1, 1, 7,  1, 0, 7,  -127};
        vecs[3] = '{0, 1, 1, 8,  1, 0, 8,  -126};
        vecs[4] = '{0, 1, 0, 9,  0, 0, 8,  -126};
        vecs[5] = '{0, 1, 1, 11, 1, 0, 11, -128};
        vecs[6] = '{1, 1, 1, 12, 0, 0, 11, 0};
        vecs[7] = '{0, 1, 1, 13, 1, 0, 13, -128};
        foreach (vecs[k]) begin
            cycle(vecs[k].dl, 0, 0, vecs[k].dv, vecs[k].fv, vecs[k].d);
            chk($sformatf("vec%0d_dvi", k), dvi_o, vecs[k].x_dvi);
            chk($sformatf("vec%0d_nb", k), newblock_o, vecs[k].x_nb);
            chk($sformatf("vec%0d_data", k), data_o, vecs[k].x_data);
            chk($sformatf("vec%0d_coeff", k), sc(svcoeff_o), vecs[k].x_coeff);
        end

        // Reload, then a full line at full rate
        load_ramp(0);
        cycle(0, 0, 0, 0, 0, 0);
        nb_cnt = 0;
        for (int i = 0; i < IMW; i++) begin
            pix(i);
            chk("line_coeff", sc(svcoeff_o), (i % DEPTH) - 128);
            chk("line_data", data_o, i & 8'hff);
            chk("line_nb", newblock_o, int'((i % BS) == BS - 1));
            nb_cnt += newblock_o;
        end
        chk("line_nb_pulses", nb_cnt, 10);

        // Same line with one pixel every three cycles
        nb_cnt = 0; dvi_cnt = 0;
        for (int i = 0; i < IMW; i++) begin
            pix(i);
            chk("gap_coeff", sc(svcoeff_o), (i % DEPTH) - 128);
            chk("gap_nb", newblock_o, int'((i % BS) == BS - 1));
            nb_cnt += newblock_o; dvi_cnt += dvi_o;
            idle(); dvi_cnt += dvi_o;
            idle(); dvi_cnt += dvi_o;
        end
        chk("gap_nb_pulses", nb_cnt, 10);
        chk("gap_dvi_count", dvi_cnt, IMW);

        // Download in the middle of a line
        for (int i = 0; i < 40; i++) pix(i);
        cycle(1, 0, 0, 1, 1, 99);
        chk("mid_dl_dvi", dvi_o, 0);
        cycle(1, 0, 0, 1, 1, 98);
        cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < BS; i++) begin
            pix(200 + i);
            if (i == 0) chk("after_dl_first", sc(svcoeff_o), -128);
            chk("after_dl_nb", newblock_o, int'(i == BS - 1));
        end

        // Reset in the middle of a line
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) pix(i);
        pulse_reset();
        pix(3);
        chk("after_rst_first", sc(svcoeff_o), -128);

        // Frame valid dropped after 50 pixels
        for (int i = 0; i < 50; i++) pix(i);
        cycle(0, 0, 0, 1, 0, 0);
        pix(4);
        chk("after_fv_first", sc(svcoeff_o), -128);

        // Overflowing download: 257 writes
        load_ramp(1);
        chk("ovf_loaded", loaded_o, 1);
        chk("ovf_flag", ovf_o, 1);
        cycle(0, 0, 0, 0, 0, 0);
        pix(1);
        chk("ovf_mem0", sc(svcoeff_o), -128);
        cycle(1, 0, 0, 0, 1, 0);
        chk("redl_loaded", loaded_o, 0);
        chk("redl_ovf", ovf_o, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model
        r_dl = 0;
        for (int i = 0; i < 3000; i++) begin
            int v;
            if ($urandom_range(0, 39) == 0) r_dl = !r_dl;
            v = int'($urandom_range(0, 511));
            if (v >= 256) v -= 512;
            cycle(r_dl[0], $urandom_range(0, 1) == 1, v,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0,
                  int'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
